// File: rtl/ddr_wr_packer.sv
// Packs 16-bit pixels into 128-bit words, buffers them in a FIFO and issues req/ack DDR write bursts.
// Latency: a packed word shows in fill_level one cycle after its last pixel; wr_data is head-of-FIFO, same cycle.
// Backpressure: pix_ready drops while the FIFO is full or a flushed frame drains. Macro: DDR_WR_PACK_MSB_FIRST_EN.

module ddr_wr_fifo #(
    parameter int W  = 128,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(2**AW);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end
endmodule

module ddr_wr_packer #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 128,
    parameter int LANES     = 8,
    parameter int DEPTH_W   = 6,
    parameter int BURST_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [IN_W-1:0]    pix_data,
    input  logic               pix_last,
    output logic               burst_req,
    input  logic               burst_ack,
    output logic [7:0]         burst_len,
    input  logic               wr_data_req,
    output logic [OUT_W-1:0]   wr_data,
    output logic [DEPTH_W:0]   fill_level,
    output logic               frame_done
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0]    LAST_LANE  = LW'(LANES-1);
    localparam logic [DEPTH_W:0] BURST_FILL = (DEPTH_W+1)'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t           state, state_nxt;
    logic [LW-1:0]    lane;
    logic [LW-1:0]    slot;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] word_nxt;
    logic             flush_pending;
    logic [7:0]       beat;
    logic             accept, push, pop, full, empty;
    logic             latch, done;
    logic [7:0]       latch_len;
    logic             req_c;

    assign pix_ready = rst_n & ~full & ~flush_pending;
    assign accept    = pix_valid & pix_ready;
    assign push      = accept & ((lane == LAST_LANE) | pix_last);

`ifdef DDR_WR_PACK_MSB_FIRST_EN
    assign slot = LAST_LANE - lane;
`else
    assign slot = lane;
`endif

    // acc holds only lanes already written, so unused lanes of a short word stay zero
    always_comb begin
        word_nxt = acc;
        word_nxt[int'(slot)*IN_W +: IN_W] = pix_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane <= '0;
            acc  <= '0;
        end else if (accept) begin
            if (push) begin
                lane <= '0;
                acc  <= '0;
            end else begin
                lane <= lane + LW'(1);
                acc  <= word_nxt;
            end
        end
    end

    ddr_wr_fifo #(.W(OUT_W), .AW(DEPTH_W)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (word_nxt),
        .pop      (pop),
        .head_dat (wr_data),
        .count    (fill_level),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        latch_len = '0;
        pop       = 1'b0;
        done      = 1'b0;
        req_c     = 1'b0;
        case (state)
            IDLE: begin
                if (fill_level >= BURST_FILL) begin
                    state_nxt = REQ;
                    latch     = 1'b1;
                    latch_len = 8'(BURST_LEN);
                end else if (flush_pending && !empty) begin
                    state_nxt = REQ;
                    latch     = 1'b1;
                    latch_len = 8'(fill_level);
                end else if (flush_pending) begin
                    done = 1'b1;
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (burst_ack) state_nxt = DATA;
            end
            DATA: begin
                if (wr_data_req) begin
                    pop = 1'b1;
                    if ((beat + 8'd1) == burst_len) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign burst_req  = rst_n & req_c;
    assign frame_done = rst_n & done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_len     <= '0;
            beat          <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (latch) burst_len <= latch_len;
            if (state == REQ && burst_ack) beat <= '0;
            else if (pop)                  beat <= beat + 8'd1;
            if (done)                      flush_pending <= 1'b0;
            else if (accept && pix_last)   flush_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr_wr_packer.sv
// Bench for ddr_wr_packer: queue-based reference model checked every cycle, plus literal checks of key scenarios.
module tb_ddr_wr_packer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic [15:0]  pix_data = '0;
    logic         pix_last = 1'b0;
    logic         burst_req;
    logic         burst_ack = 1'b0;
    logic [7:0]   burst_len;
    logic         wr_data_req = 1'b0;
    logic [127:0] wr_data;
    logic [6:0]   fill_level;
    logic         frame_done;

    int n_chk = 0;
    int n_fail = 0;

    ddr_wr_packer dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .burst_req(burst_req),
        .burst_ack(burst_ack), .burst_len(burst_len), .wr_data_req(wr_data_req),
        .wr_data(wr_data), .fill_level(fill_level), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words in FIFO order, pixels of the word being built, burst bookkeeping
    logic [127:0] mq [$];
    logic [15:0]  pbuf [$];
    bit           m_flush = 0;
    int           m_phase = 0;   // 0 idle, 1 requesting, 2 transferring
    int           m_blen = 0;
    int           m_cnt = 0;
    bit           chk_en = 0;
    int           m_sz;
    bit           m_rdy, m_pop, m_done;

    function automatic logic [127:0] build_word();
        logic [127:0] w = '0;
        for (int i = 0; i < pbuf.size(); i++) begin
`ifdef DDR_WR_PACK_MSB_FIRST_EN
            w[(7-i)*16 +: 16] = pbuf[i];
`else
            w[i*16 +: 16] = pbuf[i];
`endif
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete(); pbuf.delete();
            m_flush = 0; m_phase = 0; m_blen = 0; m_cnt = 0;
            chk_en = 1;
        end else begin
            m_sz   = mq.size();
            m_rdy  = (m_sz < 64) && !m_flush;
            m_pop  = (m_phase == 2) && wr_data_req;
            m_done = (m_phase == 0) && m_flush && (m_sz == 0);
            case (m_phase)
                0: if (m_sz >= 16) begin m_phase = 1; m_blen = 16; end
                   else if (m_flush && m_sz > 0) begin m_phase = 1; m_blen = m_sz; end
                1: if (burst_ack) begin m_phase = 2; m_cnt = 0; end
                2: if (m_pop) begin m_cnt++; if (m_cnt == m_blen) m_phase = 0; end
                default: m_phase = 0;
            endcase
            if (m_done) m_flush = 0;
            if (m_pop && mq.size() > 0) void'(mq.pop_front());
            if (pix_valid && m_rdy) begin
                pbuf.push_back(pix_data);
                if (pbuf.size() == 8 || pix_last) begin
                    mq.push_back(build_word());
                    pbuf.delete();
                    if (pix_last) m_flush = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model pix_ready", pix_ready, rst_n && (mq.size() < 64) && !m_flush);
            chk("model fill_level", fill_level, mq.size());
            chk("model burst_req", burst_req, rst_n && (m_phase == 1));
            chk("model burst_len", burst_len, m_blen);
            chk("model frame_done", frame_done, rst_n && (m_phase == 0) && m_flush && (mq.size() == 0));
            if (mq.size() > 0) chk("model wr_data", wr_data, mq[0]);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        pix_valid = 0; pix_last = 0; burst_ack = 0; wr_data_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst pix_ready", pix_ready, 0);
        chk("rst fill_level", fill_level, 0);
        chk("rst burst_req", burst_req, 0);
        chk("rst burst_len", burst_len, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst wr_data", wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst pix_ready", pix_ready, 1);
        chk("post-rst fill_level", fill_level, 0);
        @(posedge clk); #1;
    endtask

    task automatic send_pix(input logic [15:0] d, input logic l);
        int t = 0;
        pix_valid = 1; pix_data = d; pix_last = l;
        @(negedge clk);
        while (!pix_ready && t < 2000) begin @(negedge clk); t++; end
        if (!pix_ready) chk("pixel accept timeout", 0, 1);
        @(posedge clk); #1;
        pix_valid = 0; pix_last = 0;
    endtask

    task automatic wait_req();
        int t = 0;
        @(negedge clk);
        while (!burst_req && t < 200) begin @(negedge clk); t++; end
        chk("burst_req seen", burst_req, 1);
    endtask

    task automatic ack();
        burst_ack = 1;
        @(posedge clk); #1;
        burst_ack = 0;
    endtask

    task automatic pull(input int n);
        wr_data_req = 1;
        repeat (n) @(posedge clk);
        #1;
        wr_data_req = 0;
    endtask

    logic [127:0] exp_w1, exp_w2, exp_w3;
    int seen;

    initial begin
`ifdef DDR_WR_PACK_MSB_FIRST_EN
        exp_w1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        exp_w2 = {16'h0109, 16'h010A, 16'h010B, 80'h0};
        exp_w3 = 128'h0011_0012_0013_0014_0015_0016_0017_0018;
`else
        exp_w1 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        exp_w2 = {80'h0, 16'h010B, 16'h010A, 16'h0109};
        exp_w3 = 128'h0018_0017_0016_0015_0014_0013_0012_0011;
`endif
        // reset and single-word pack
        do_reset();
        for (int i = 1; i <= 8; i++) send_pix(16'(i), 0);
        @(negedge clk);
        chk("pack fill_level", fill_level, 1);
        chk("pack wr_data", wr_data, exp_w1);

        // full burst of 16
        do_reset();
        for (int i = 0; i < 128; i++) send_pix(16'h2000 + 16'(i), 0);
        wait_req();
        chk("burst burst_len", burst_len, 16);
        ack();
        pull(16);
        @(negedge clk);
        chk("burst drained fill", fill_level, 0);
        chk("burst drained req", burst_req, 0);

        // flush of a partial frame
        do_reset();
        for (int i = 1; i <= 11; i++) send_pix(16'h0100 + 16'(i), i == 11);
        wait_req();
        chk("flush burst_len", burst_len, 2);
        chk("flush word1", wr_data, {exp_w1[127:0] | 128'h0100_0100_0100_0100_0100_0100_0100_0100});
        ack();
        pull(1);
        @(negedge clk);
        chk("flush word2", wr_data, exp_w2);
        @(posedge clk); #1;
        pull(1);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        chk("frame_done pulse", seen, 1);
        @(negedge clk);
        chk("frame_done one cycle", frame_done, 0);
        chk("flush pix_ready back", pix_ready, 1);

        // full FIFO and backpressure
        do_reset();
        for (int i = 0; i < 512; i++) send_pix(16'h4000 + 16'(i), 0);
        @(negedge clk);
        chk("full fill_level", fill_level, 64);
        chk("full pix_ready", pix_ready, 0);
        chk("full burst_len", burst_len, 16);
        @(posedge clk); #1;
        ack();
        pull(16);
        @(negedge clk);
        chk("after pulls pix_ready", pix_ready, 1);
        @(posedge clk); #1;
        pull(3);
        @(negedge clk);
        chk("extra pulls no pop", fill_level, 48);

        // reset during a transfer
        do_reset();
        for (int i = 0; i < 131; i++) send_pix(16'h6000 + 16'(i), 0);
        wait_req();
        @(posedge clk); #1;
        ack();
        pull(5);
        do_reset();
        for (int i = 1; i <= 8; i++) send_pix(16'h0010 + 16'(i), 0);
        @(negedge clk);
        chk("repack fill_level", fill_level, 1);
        chk("repack wr_data", wr_data, exp_w3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
